// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared constants for the stage-1 fetch unit: NOP encoding, default reset
// PC, the RV32I opcodes the fetch pre-decode looks at, and the fetch FSM
// state encoding.
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_2000;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_bpred.sv
// ----------------------------------------------------------------------------
// fetch_bpred
// Static backward-taken / forward-not-taken predictor. Purely combinational:
// extracts the B- and J-type immediates of the presented instruction and
// forms the predicted target.
//   pc      in   address of the presented instruction
//   instr   in   presented instruction word
//   taken   out  1 = backward conditional branch or JAL
//   target  out  pc + sign-extended immediate
// ----------------------------------------------------------------------------
module fetch_bpred
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               taken,
  output logic [ADDR_W-1:0]  target
);

  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_branch;
  logic        is_jal;

  always_comb begin
    b_imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    j_imm     = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    is_branch = (instr[6:0] == OPC_BRANCH);
    is_jal    = (instr[6:0] == OPC_JAL);
    taken     = (is_branch && instr[31]) || is_jal;
    target    = is_jal ? pc + ADDR_W'(j_imm) : pc + ADDR_W'(b_imm);
  end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Stage-1 instruction fetch for the RV32I pipeline. Drives the icache request
// address, presents pc/instr to decode and reacts to decode's stall/kill
// back-channel. Optional static prediction is enabled with BPRED_BTFN_EN.
//   clk           in   clock
//   rst           in   asynchronous active-low reset
//   icache_addr   out  word-aligned request address (combinational)
//   icache_re     out  read enable
//   icache_dout   in   read data, valid the cycle after a non-stalled request
//   icache_stall  in   icache busy/miss, request held stable while high
//   pc            out  address of the instruction on instr
//   instr         out  instruction to decode, NOP when invalid
//   bpred         out  instruction on instr was predicted taken
//   stall         in   decode data-dependency stall
//   kill          in   decode redirect
//   br_j          in   resolved direction, 1 = taken branch/jump
//   cntrl_addr    in   resolved target when br_j=1
//
// state | meaning
// BOOT  | first request (RESET_PC) after reset, nothing presented
// RUN   | icache data presented, next request follows prediction/redirect
// WAIT  | icache miss, request held; pending redirect issued on exit
// HOLD  | decode stalled, skid register presented, pc_f frozen
// ----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  icache_addr,
  output logic               icache_re,
  input  logic [INSTR_W-1:0] icache_dout,
  input  logic               icache_stall,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               bpred,
  input  logic               stall,
  input  logic               kill,
  input  logic               br_j,
  input  logic [ADDR_W-1:0]  cntrl_addr
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  fetch_state_e       state, state_nxt;
  logic [ADDR_W-1:0]  pc_f, pc_f_nxt;
  logic [INSTR_W-1:0] hold_instr, hold_instr_nxt;
  logic               hold_vld, hold_vld_nxt;
  logic [ADDR_W-1:0]  pend_addr, pend_addr_nxt;
  logic               pend_vld, pend_vld_nxt;

  logic [INSTR_W-1:0] cur_instr;
  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  pred_pc;
  logic               pred_taken;
  logic [ADDR_W-1:0]  redirect;
  logic [ADDR_W-1:0]  req_addr;

  // While held, prediction must come from the skid copy, not the bus.
  assign cur_instr = (state == FETCH_HOLD && hold_vld) ? hold_instr : icache_dout;
  assign seq_pc    = pc_f + ADDR_W'(4);
  assign redirect  = br_j ? (cntrl_addr & WORD_MASK) : seq_pc;

`ifdef BPRED_BTFN_EN
  logic [ADDR_W-1:0] bp_target;

  fetch_bpred #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_bpred (
    .pc     (pc_f),
    .instr  (cur_instr),
    .taken  (pred_taken),
    .target (bp_target)
  );

  assign pred_pc = (pred_taken ? bp_target : seq_pc) & WORD_MASK;
`else
  assign pred_taken = 1'b0;
  assign pred_pc    = seq_pc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH_BOOT;
      pc_f       <= RESET_PC;
      hold_instr <= NOP_INSTR[INSTR_W-1:0];
      hold_vld   <= 1'b0;
      pend_addr  <= RESET_PC;
      pend_vld   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_f       <= pc_f_nxt;
      hold_instr <= hold_instr_nxt;
      hold_vld   <= hold_vld_nxt;
      pend_addr  <= pend_addr_nxt;
      pend_vld   <= pend_vld_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_f_nxt       = pc_f;
    req_addr       = pc_f;
    hold_instr_nxt = hold_instr;
    hold_vld_nxt   = hold_vld;
    pend_addr_nxt  = pend_addr;
    pend_vld_nxt   = pend_vld;

    unique case (state)
      FETCH_BOOT: begin
        req_addr  = RESET_PC;
        pc_f_nxt  = RESET_PC;
        state_nxt = icache_stall ? FETCH_WAIT : FETCH_RUN;
      end

      FETCH_RUN, FETCH_HOLD: begin
        if (kill) begin
          hold_vld_nxt = 1'b0;
          if (icache_stall) begin
            // Keep the outstanding request on the bus; redirect after the miss.
            req_addr      = (state == FETCH_RUN) ? pc_f : pred_pc;
            pc_f_nxt      = req_addr;
            pend_addr_nxt = redirect;
            pend_vld_nxt  = 1'b1;
            state_nxt     = FETCH_WAIT;
          end else begin
            req_addr     = redirect;
            pc_f_nxt     = redirect;
            pend_vld_nxt = 1'b0;
            state_nxt    = FETCH_RUN;
          end
        end else if (state == FETCH_RUN && icache_stall) begin
          req_addr  = pc_f;
          state_nxt = FETCH_WAIT;
        end else if (stall) begin
          // The request already issued is simply repeated until release.
          req_addr = pred_pc;
          if (state == FETCH_RUN) begin
            hold_instr_nxt = icache_dout;
            hold_vld_nxt   = 1'b1;
            state_nxt      = FETCH_HOLD;
          end
        end else begin
          req_addr     = pred_pc;
          pc_f_nxt     = pred_pc;
          hold_vld_nxt = 1'b0;
          state_nxt    = FETCH_RUN;
        end
      end

      FETCH_WAIT: begin
        if (kill) begin
          if (icache_stall) begin
            req_addr      = pc_f;
            pend_addr_nxt = redirect;
            pend_vld_nxt  = 1'b1;
          end else begin
            req_addr     = redirect;
            pc_f_nxt     = redirect;
            pend_vld_nxt = 1'b0;
            state_nxt    = FETCH_RUN;
          end
        end else if (icache_stall) begin
          req_addr = pc_f;
        end else if (pend_vld) begin
          req_addr     = pend_addr;
          pc_f_nxt     = pend_addr;
          pend_vld_nxt = 1'b0;
          state_nxt    = FETCH_RUN;
        end else begin
          req_addr  = pc_f;
          state_nxt = FETCH_RUN;
        end
      end

      default: begin
        state_nxt = FETCH_BOOT;
      end
    endcase
  end

  always_comb begin
    instr = NOP_INSTR[INSTR_W-1:0];
    bpred = 1'b0;
    unique case (state)
      FETCH_RUN: begin
        if (!kill && !icache_stall) begin
          instr = icache_dout;
          bpred = pred_taken;
        end
      end
      FETCH_HOLD: begin
        if (!kill) begin
          instr = cur_instr;
          bpred = pred_taken;
        end
      end
      default: begin
        instr = NOP_INSTR[INSTR_W-1:0];
        bpred = 1'b0;
      end
    endcase
  end

  assign icache_addr = req_addr & WORD_MASK;
  assign icache_re   = rst;
  assign pc          = pc_f;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/100ps
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout;
  logic        icache_stall = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        bpred;
  logic        stall = 1'b0;
  logic        kill = 1'b0;
  logic        br_j = 1'b0;
  logic [31:0] cntrl_addr = 32'h0;

  logic [31:0] mem [0:4095];
  logic [31:0] addr_q = 32'h0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .icache_addr  (icache_addr),
    .icache_re    (icache_re),
    .icache_dout  (icache_dout),
    .icache_stall (icache_stall),
    .pc           (pc),
    .instr        (instr),
    .bpred        (bpred),
    .stall        (stall),
    .kill         (kill),
    .br_j         (br_j),
    .cntrl_addr   (cntrl_addr)
  );

  always #5 clk = ~clk;

  // Synchronous icache: data for the address seen at an edge appears after it.
  always @(posedge clk) addr_q <= icache_addr;
  assign icache_dout = mem[addr_q[13:2]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem[a[13:2]];
  endfunction

  function automatic logic bp_of(input logic [31:0] i);
`ifdef BPRED_BTFN_EN
    return (i[6:0] == 7'b1100011 && i[31]) || (i[6:0] == 7'b1101111);
`else
    return 1'b0;
`endif
  endfunction

  // Address fetched after the instruction at a, from the prediction rules.
  function automatic logic [31:0] next_of(input logic [31:0] a);
    logic [31:0] i;
    int          off;
    i   = rd(a);
    off = 4;
`ifdef BPRED_BTFN_EN
    if (i[6:0] == 7'b1100011 && i[31])
      off = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
    else if (i[6:0] == 7'b1101111)
      off = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
`endif
    return (a + 32'(off)) & ~32'h3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic k, input logic bj, input logic [31:0] ca,
                     input logic st, input logic ics);
    @(posedge clk);
    #1;
    kill = k; br_j = bj; cntrl_addr = ca; stall = st; icache_stall = ics;
    @(negedge clk);
  endtask

  task automatic run_cycle(input string tag);
    cyc(1'b0, 1'b0, $urandom, 1'b0, 1'b0);
    chk({tag, " pc"}, pc, cur);
    chk({tag, " instr"}, instr, rd(cur));
    chk({tag, " bpred"}, 32'(bpred), 32'(bp_of(rd(cur))));
    chk({tag, " addr"}, icache_addr, next_of(cur));
    cur = next_of(cur);
  endtask

  task automatic kill_cycle(input string tag, input logic bj, input logic [31:0] ca, input logic st);
    logic [31:0] exp;
    exp = bj ? (ca & ~32'h3) : cur + 32'd4;
    cyc(1'b1, bj, ca, st, 1'b0);
    chk({tag, " pc"}, pc, cur);
    chk({tag, " instr"}, instr, NOP);
    chk({tag, " bpred"}, 32'(bpred), 32'd0);
    chk({tag, " addr"}, icache_addr, exp);
    cur = exp;
  endtask

  task automatic wait_chk(input string tag, input logic [31:0] exp_addr);
    chk({tag, " instr"}, instr, NOP);
    chk({tag, " bpred"}, 32'(bpred), 32'd0);
    chk({tag, " addr"}, icache_addr, exp_addr);
  endtask

  task automatic hold_chk(input string tag, input logic [31:0] a);
    chk({tag, " pc"}, pc, a);
    chk({tag, " instr"}, instr, rd(a));
    chk({tag, " addr"}, icache_addr, next_of(a));
  endtask

  task automatic do_reset(input string tag);
    kill = 1'b0; stall = 1'b0; icache_stall = 1'b0; br_j = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk({tag, " rst pc"}, pc, 32'h2000);
    chk({tag, " rst instr"}, instr, NOP);
    chk({tag, " rst bpred"}, 32'(bpred), 32'd0);
    chk({tag, " rst re"}, 32'(icache_re), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk({tag, " boot instr"}, instr, NOP);
    chk({tag, " boot re"}, 32'(icache_re), 32'd1);
    chk({tag, " boot addr"}, icache_addr, 32'h2000);
    cur = 32'h2000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tmp, s, tgt, pend;
    logic        pend_set;
    int          n;

    for (int i = 0; i < 4096; i++) begin
      tmp    = $urandom;
      mem[i] = {tmp[31:7], 7'b0110011};
    end
    // beq x1,x2,-16 at 0x2040
    mem[12'h810] = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b1, 7'b1100011};

    do_reset("init");

    // sequential fetch then taken redirect at 0x2008
    run_cycle("seq0");
    run_cycle("seq1");
    chk("at 0x2008", cur, 32'h2008);
    tmp = $urandom;
    kill_cycle("kill_t", 1'b1, 32'h2100 | {30'd0, tmp[1:0]}, 1'b0);
    run_cycle("tgt2100");

    // back-to-back kills: to 0x2010, then not-taken resume at 0x2014
    kill_cycle("kill_2010", 1'b1, 32'h2010, 1'b0);
    kill_cycle("kill_nt", 1'b0, $urandom, 1'b0);
    run_cycle("resume2014");

    // random redirects
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) run_cycle("rseq");
      tgt = 32'h2000 + ($urandom_range(0, 2047) << 2) + $urandom_range(0, 3);
      kill_cycle("rkill", 1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)));
      run_cycle("rtgt");
    end

    // icache miss 3 cycles, redirect to 0x3000 during the 2nd
    s = cur;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); wait_chk("miss1", s);
    cyc(1'b1, 1'b1, 32'h3000, 1'b0, 1'b1); wait_chk("miss2", s);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); wait_chk("miss3", s);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); wait_chk("miss_exit", 32'h3000);
    cur = 32'h3000;
    run_cycle("after_miss");

    // random miss episodes, possibly several kills (last one wins)
    for (int r = 0; r < 4; r++) begin
      s        = cur;
      pend_set = 1'b0;
      pend     = 32'h0;
      n        = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        tgt = 32'h2000 + ($urandom_range(0, 2047) << 2);
        if ($urandom_range(0, 1) == 1) begin
          pend_set = 1'b1;
          pend     = tgt;
          cyc(1'b1, 1'b1, tgt, 1'b0, 1'b1);
        end else begin
          cyc(1'b0, 1'b0, tgt, 1'b0, 1'b1);
        end
        wait_chk("rmiss", s);
      end
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      wait_chk("rmiss_exit", pend_set ? pend : s);
      cur = pend_set ? pend : s;
      run_cycle("rmiss_after");
    end

    // decode stall 2 cycles at 0x2020
    kill_cycle("to2020", 1'b1, 32'h2020, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); hold_chk("hold1", 32'h2020);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); hold_chk("hold2", 32'h2020);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); hold_chk("hold_rel", 32'h2020);
    cur = next_of(32'h2020);
    chk("no skip", cur, 32'h2024);
    run_cycle("after_hold");

    // random stall lengths
    for (int r = 0; r < 3; r++) begin
      s = cur;
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); hold_chk("rhold", s);
      end
      run_cycle("rhold_rel");
    end

    // kill wins over stall while held
    s = cur;
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); hold_chk("hk_hold", s);
    tgt = 32'h2000 + ($urandom_range(0, 2047) << 2);
    kill_cycle("hk_kill", 1'b1, tgt, 1'b1);
    run_cycle("hk_tgt");

    // backward branch at 0x2040, imm -16
    kill_cycle("to2040", 1'b1, 32'h2040, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("br pc", pc, 32'h2040);
`ifdef BPRED_BTFN_EN
    chk("br bpred", 32'(bpred), 32'd1);
    chk("br next", icache_addr, 32'h2030);
    cur = 32'h2030;
`else
    chk("br bpred", 32'(bpred), 32'd0);
    chk("br next", icache_addr, 32'h2044);
    cur = 32'h2044;
`endif
    run_cycle("br_after");

    // reset during a miss with a pending redirect
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'h3800, 1'b0, 1'b1);
    do_reset("rst_wait");
    run_cycle("rw0");
    run_cycle("rw1");

    // reset while held
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); hold_chk("rh_hold", cur);
    do_reset("rst_hold");
    run_cycle("rh0");

    kill = 1'b0; stall = 1'b0; icache_stall = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
